// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with register-file writeback.
// Radix-2 shift-add multiply and restoring divide on magnitudes, one bit per cycle.
// Optional macro MULDIV_FLUSH_EN adds a flush input that aborts the op in flight.
module muldiv_unit #(
    parameter int A_WIDTH = 5,
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
`ifdef MULDIV_FLUSH_EN
    input  logic               flush,
`endif
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [D_WIDTH-1:0] rs1_val,
    input  logic [D_WIDTH-1:0] rs2_val,
    input  logic [A_WIDTH-1:0] rd_addr,
    output logic               busy,
    output logic               done,
    output logic [D_WIDTH-1:0] result,
    output logic               wb_we,
    output logic [A_WIDTH-1:0] wb_addr,
    output logic [D_WIDTH-1:0] wb_data
);

    localparam int CNT_W = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;
    localparam int P_W   = 2 * D_WIDTH;
    localparam logic [D_WIDTH-1:0] MIN_NEG = {1'b1, {(D_WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(D_WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t state, state_nxt;

    // Latched operation context
    logic [2:0]         op_q;
    logic [D_WIDTH-1:0] opnd_q;     // multiplicand or divisor magnitude
    logic [D_WIDTH-1:0] acc_hi;     // product high half / partial remainder
    logic [D_WIDTH-1:0] acc_lo;     // multiplier->product low half / dividend->quotient
    logic               neg_q;      // product or quotient sign
    logic               rneg_q;     // remainder sign
    logic [CNT_W-1:0]   count;

    // Two's-complement conditional negation helpers
    function automatic logic [D_WIDTH-1:0] cneg_w(input logic [D_WIDTH-1:0] v, input logic en);
        return en ? ((~v) + D_WIDTH'(1)) : v;
    endfunction

    function automatic logic [P_W-1:0] cneg_p(input logic [P_W-1:0] v, input logic en);
        return en ? ((~v) + P_W'(1)) : v;
    endfunction

    // Accept-time decode
    logic                      is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic signed [D_WIDTH-1:0] a_s, b_s;
    logic [D_WIDTH-1:0]        a_mag, b_mag, spec_res;
    logic                      div_zero, div_ovf, special;

    assign a_s = rs1_val;
    assign b_s = rs2_val;

    // Operand signedness, magnitudes and the divide special cases
    always_comb begin
        is_div   = op[2];
        a_sgn    = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        b_sgn    = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        a_neg    = a_sgn && (a_s < 0);
        b_neg    = b_sgn && (b_s < 0);
        a_mag    = cneg_w(rs1_val, a_neg);
        b_mag    = cneg_w(rs2_val, b_neg);
        div_zero = is_div && (rs2_val == '0);
        // Signed ops (DIV/REM) have op[0] clear
        div_ovf  = is_div && !op[0] && (rs1_val == MIN_NEG) && (rs2_val == '1);
        special  = div_zero || div_ovf;
        spec_res = '0;
        if (div_zero)
            spec_res = op[1] ? rs1_val : '1;
        else if (div_ovf)
            spec_res = op[1] ? '0 : MIN_NEG;
    end

    // One iteration of the shared datapath
    logic [D_WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [D_WIDTH-1:0] nxt_hi, nxt_lo;

    // Shift-add for multiply, trial-subtract-and-restore for divide
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_hi, acc_lo[D_WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        nxt_hi    = acc_hi;
        nxt_lo    = acc_lo;
        if (!op_q[2]) begin
            nxt_hi = mul_sum[D_WIDTH:1];
            nxt_lo = {mul_sum[0], acc_lo[D_WIDTH-1:1]};
        end else if (!div_diff[D_WIDTH]) begin
            nxt_hi = div_diff[D_WIDTH-1:0];
            nxt_lo = {acc_lo[D_WIDTH-2:0], 1'b1};
        end else begin
            nxt_hi = div_shift[D_WIDTH-1:0];
            nxt_lo = {acc_lo[D_WIDTH-2:0], 1'b0};
        end
    end

    // Final result formed from the values the last iteration produces
    logic [P_W-1:0]     prod_s;
    logic [D_WIDTH-1:0] fin_res;

    // Sign fix-up and half/quotient/remainder selection
    always_comb begin
        prod_s  = cneg_p({nxt_hi, nxt_lo}, neg_q);
        fin_res = '0;
        if (!op_q[2])
            fin_res = (op_q[1:0] == 2'd0) ? prod_s[D_WIDTH-1:0] : prod_s[P_W-1:D_WIDTH];
        else if (op_q[1])
            fin_res = cneg_w(nxt_hi, rneg_q);
        else
            fin_res = cneg_w(nxt_lo, neg_q);
    end

    logic kill;
`ifdef MULDIV_FLUSH_EN
    assign kill = flush;
`else
    assign kill = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; kill aborts a busy op and blocks acceptance in IDLE
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start && !kill)
                    state_nxt = special ? S_DONE : S_CALC;
            end
            S_CALC: begin
                if (kill)
                    state_nxt = S_IDLE;
                else if (count == LAST_CNT)
                    state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake and writeback outputs
    always_comb begin
        busy    = (state != S_IDLE);
        done    = (state == S_DONE) && !kill;
        wb_we   = done && (wb_addr != '0);
        wb_data = result;
    end

    logic accept, step, last;
    assign accept = (state == S_IDLE) && (state_nxt != S_IDLE);
    assign step   = (state == S_CALC) && (state_nxt != S_IDLE);
    assign last   = (state == S_CALC) && (state_nxt == S_DONE);

    // Operand capture at accept, iteration in CALC, result update on entry to DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            opnd_q  <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            count   <= '0;
            result  <= '0;
            wb_addr <= '0;
        end else if (accept) begin
            op_q    <= op;
            wb_addr <= rd_addr;
            count   <= '0;
            acc_hi  <= '0;
            acc_lo  <= is_div ? a_mag : b_mag;
            opnd_q  <= is_div ? b_mag : a_mag;
            neg_q   <= a_neg ^ b_neg;
            rneg_q  <= a_neg;
            if (special)
                result <= spec_res;
        end else if (step) begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            count  <= count + CNT_W'(1);
            if (last)
                result <= fin_res;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed RV32M vectors, latency,
// special cases, held start, async reset abort and (with MULDIV_FLUSH_EN) flush.
module tb_muldiv_unit;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    op;
    logic [DW-1:0] rs1_val, rs2_val;
    logic [AW-1:0] rd_addr;
    logic          busy, done, wb_we;
    logic [DW-1:0] result, wb_data;
    logic [AW-1:0] wb_addr;
`ifdef MULDIV_FLUSH_EN
    logic          flush;
`endif

    muldiv_unit #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
        .clk     (clk),
        .rst     (rst),
`ifdef MULDIV_FLUSH_EN
        .flush   (flush),
`endif
        .start   (start),
        .op      (op),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd_addr (rd_addr),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .wb_we   (wb_we),
        .wb_addr (wb_addr),
        .wb_data (wb_data)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op; exp_cyc is the index of the done cycle, 1 = cycle right after accept
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input int exp_cyc,
                          input logic [31:0] exp_res, input bit poke);
        int cyc;
        int bcnt;
        @(negedge clk);
        op = o; rs1_val = a; rs2_val = b; rd_addr = rd; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = ~o; rs1_val = ~a; rs2_val = b ^ 32'h5a5a_0f0f; rd_addr = ~rd;
        cyc  = 1;
        bcnt = 0;
        while (1) begin
            if (busy) bcnt++;
            if (done || cyc >= 40) break;
            if (poke && cyc == 10) begin
                start = 1'b1; op = 3'd0; rs1_val = 32'd9; rs2_val = 32'd9; rd_addr = 5'd31;
            end
            if (poke && cyc == 12) start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk({tag, " done_cyc"}, cyc, exp_cyc);
        chk({tag, " result"}, result, exp_res);
        chk({tag, " wb_data"}, wb_data, exp_res);
        chk({tag, " wb_addr"}, wb_addr, rd);
        chk({tag, " wb_we"}, wb_we, (rd != 5'd0));
        chk({tag, " busy_cycles"}, bcnt, exp_cyc);
        @(negedge clk);
        chk({tag, " done_drop"}, done, 1'b0);
        chk({tag, " idle"}, busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ndone, nwe, rise, wait_cnt;
        logic prev_busy;
        rst = 1'b1; start = 1'b0; op = '0; rs1_val = '0; rs2_val = '0; rd_addr = '0;
`ifdef MULDIV_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset result", result, 32'h0);
        chk("reset wb_addr", wb_addr, 5'd0);
        chk("reset wb_we", wb_we, 1'b0);
        rst = 1'b0;

        run_op("mul",     3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  33, 32'hFFFF_FFEB, 1'b0);
        run_op("mulhu",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  33, 32'hFFFF_FFFE, 1'b0);
        run_op("mulh",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  33, 32'h0000_0000, 1'b0);
        run_op("mulhsu",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  33, 32'hFFFF_FFFF, 1'b0);
        run_op("mulh_pn", 3'd1, 32'h0001_0000, 32'hFFFE_0000, 5'd6,  33, 32'hFFFF_FFFE, 1'b0);
        run_op("div",     3'd4, 32'hFFFF_FFEC, 32'h0000_0006, 5'd4,  33, 32'hFFFF_FFFD, 1'b1);
        run_op("rem",     3'd6, 32'hFFFF_FFEC, 32'h0000_0006, 5'd7,  33, 32'hFFFF_FFFE, 1'b0);
        run_op("divu",    3'd5, 32'd20,        32'd6,         5'd8,  33, 32'd3,         1'b0);
        run_op("remu",    3'd7, 32'd20,        32'd6,         5'd9,  33, 32'd2,         1'b0);
        run_op("divu_big",3'd5, 32'hFFFF_FFFF, 32'h0000_0010, 5'd10, 33, 32'h0FFF_FFFF, 1'b0);
        run_op("div0",    3'd4, 32'd5,         32'd0,         5'd11, 1,  32'hFFFF_FFFF, 1'b0);
        run_op("rem0",    3'd6, 32'd5,         32'd0,         5'd12, 1,  32'd5,         1'b0);
        run_op("divu0",   3'd5, 32'd5,         32'd0,         5'd13, 1,  32'hFFFF_FFFF, 1'b0);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0,  1,  32'h8000_0000, 1'b0);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1,  32'h0000_0000, 1'b0);

        // start held high with rd = 0: repeated completions, never a write
        @(negedge clk);
        op = 3'd0; rs1_val = 32'd3; rs2_val = 32'd4; rd_addr = 5'd0; start = 1'b1;
        ndone = 0; nwe = 0; rise = 0; prev_busy = 1'b0;
        for (int i = 1; i <= 120; i++) begin
            @(negedge clk);
            if (busy && !prev_busy) rise = i;
            if (wb_we) nwe++;
            if (done) begin
                ndone++;
                chk("hold latency", i - rise, 32);
                chk("hold result", result, 32'd12);
            end
            prev_busy = busy;
        end
        start = 1'b0;
        chk("hold wb_we_count", nwe, 0);
        chk("hold enough_dones", (ndone >= 3), 1'b1);
        wait_cnt = 0;
        while (busy && wait_cnt < 40) begin @(negedge clk); wait_cnt++; end
        chk("hold drained", busy, 1'b0);

        // async reset in the middle of CALC
        @(negedge clk);
        op = 3'd0; rs1_val = 32'd7; rs2_val = 32'd9; rd_addr = 5'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst wb_we", wb_we, 1'b0);
        chk("rst result", result, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0; nwe = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
            if (wb_we) nwe++;
        end
        chk("rst no_done", ndone, 0);
        chk("rst no_write", nwe, 0);

`ifdef MULDIV_FLUSH_EN
        run_op("pre_flush", 3'd0, 32'd6, 32'd7, 5'd3, 33, 32'd42, 1'b0);
        @(negedge clk);
        op = 3'd0; rs1_val = 32'd2; rs2_val = 32'd2; rd_addr = 5'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy", busy, 1'b0);
        chk("flush result", result, 32'd42);
        ndone = 0; nwe = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
            if (wb_we) nwe++;
        end
        chk("flush no_done", ndone, 0);
        chk("flush no_write", nwe, 0);
        chk("flush result_kept", result, 32'd42);
        // flush in IDLE blocks a simultaneous start
        flush = 1'b1; start = 1'b1;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        chk("flush blocks_start", busy, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
